// File: rtl/lcd_numeric_display.sv
// Drives an HD44780-style character LCD in 8-bit mode, showing a binary
// value as DIGITS decimal characters refreshed once per frame.
module lcd_numeric_display #(
  parameter int unsigned VALUE_W           = 12,
  parameter int unsigned DIGITS            = 4,
  parameter int unsigned FRAME_CYCLES      = 1666667,
  parameter int unsigned POWERUP_CYCLES    = 750000,
  parameter int unsigned E_PULSE_CYCLES    = 25,
  parameter int unsigned CMD_WAIT_CYCLES   = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               write,
  input  logic               blank_zeros,
  output logic [7:0]         data,
  output logic               rs,
  output logic               rw,
  output logic               e,
  output logic               busy
);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, IDLE, CONVERT, SEND_ADDR, SEND_DIGIT
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP, PH_PULSE, PH_WAIT
  } phase_t;

  localparam int unsigned M1 =
    POWERUP_CYCLES > CLEAR_WAIT_CYCLES ?
    POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int unsigned M2 =
    CMD_WAIT_CYCLES > E_PULSE_CYCLES ?
    CMD_WAIT_CYCLES : E_PULSE_CYCLES;
  localparam int unsigned M3 = M2 > VALUE_W ? M2 : VALUE_W;
  localparam int unsigned MAXC = M1 > M3 ? M1 : M3;
  localparam int CW = $clog2(MAXC + 1);
  localparam int FW = $clog2(FRAME_CYCLES + 1);
  localparam int BW = 4 * DIGITS;
  localparam int unsigned MAXV = 10 ** DIGITS - 1;

  localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYCLES - 1);
  localparam logic [CW-1:0] E_LAST   = CW'(E_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CNV_LAST = CW'(VALUE_W - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [2:0]    DIG_LAST = 3'(DIGITS - 1);

  logic [1:0]         rsync_q;
  logic               rst_n;
  state_t             state_q, state_d;
  phase_t             phase_q, phase_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         data_q, data_d;
  logic               rs_q, rs_d;
  logic [VALUE_W-1:0] shadow_q;
  logic [VALUE_W-1:0] snap_q, snap_d;
  logic [VALUE_W-1:0] sh_q, sh_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic               blank_q, blank_d;
  logic               pend_q, pend_d;
  logic               run_q, run_d;
  logic [FW-1:0]      fcnt_q;
  logic               tick;
  logic               sat;
  logic               byte_done;
  logic [BW-1:0]      adj;
  logic [8*DIGITS-1:0] chars;
  logic [3:0]         dig;
  logic               lead;
  logic [2:0]         nidx;

  function automatic logic [7:0] init_cmd(input logic [2:0] k);
    unique case (k)
      3'd0:    init_cmd = 8'h38;
      3'd1:    init_cmd = 8'h0C;
      3'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  // Release is synchronised; assertion stays asynchronous.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rsync_q <= 2'b00;
    else          rsync_q <= {rsync_q[0], 1'b1};
  end
  assign rst_n = rsync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     shadow_q <= '0;
    else if (write) shadow_q <= value;
  end

  assign tick = run_q && (fcnt_q == FRM_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                fcnt_q <= '0;
    else if (!run_q || tick)   fcnt_q <= '0;
    else                       fcnt_q <= fcnt_q + FW'(1);
  end

  assign sat = 32'(snap_q) > MAXV;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
  end

  // Character bytes, most significant digit in the top byte.
  always_comb begin
    chars = '0;
    dig   = '0;
    lead  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dig  = sat ? 4'd9 : bcd_q[BW-1-4*i -: 4];
      lead = lead && (dig == 4'd0);
      if (blank_q && lead && (i != DIGITS - 1))
        chars[8*(DIGITS-1-i) +: 8] = 8'h20;
      else
        chars[8*(DIGITS-1-i) +: 8] = {4'h3, dig};
    end
  end

  assign nidx = idx_q + 3'd1;

  assign byte_done = (phase_q == PH_WAIT) &&
    (cnt_q == ((!rs_q && data_q == 8'h01) ?
               CLR_LAST : CMD_LAST));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    rs_d    = rs_q;
    snap_d  = snap_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    pend_d  = pend_q;
    run_d   = run_q;

    if (tick && state_q != IDLE) pend_d = 1'b1;

    if (state_q == INIT || state_q == SEND_ADDR ||
        state_q == SEND_DIGIT) begin
      unique case (phase_q)
        PH_SETUP: begin
          phase_d = PH_PULSE;
          cnt_d   = '0;
        end
        PH_PULSE: begin
          if (cnt_q == E_LAST) begin
            phase_d = PH_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PH_WAIT:  cnt_d = cnt_q + CW'(1);
        default:  phase_d = PH_SETUP;
      endcase
    end

    unique case (state_q)
      PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d = INIT;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
          data_d  = init_cmd(3'd0);
          rs_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      INIT: begin
        if (byte_done) begin
          phase_d = PH_SETUP;
          cnt_d   = '0;
          if (idx_q == 3'd3) begin
            state_d = IDLE;
            run_d   = 1'b1;
          end else begin
            idx_d  = nidx;
            data_d = init_cmd(nidx);
          end
        end
      end
      IDLE: begin
        if (tick || pend_q) begin
          state_d = CONVERT;
          cnt_d   = '0;
          snap_d  = shadow_q;
          sh_d    = shadow_q;
          bcd_d   = '0;
          blank_d = blank_zeros;
          pend_d  = 1'b0;
        end
      end
      CONVERT: begin
        bcd_d = {adj[BW-2:0], sh_q[VALUE_W-1]};
        sh_d  = {sh_q[VALUE_W-2:0], 1'b0};
        if (cnt_q == CNV_LAST) begin
          state_d = SEND_ADDR;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          data_d  = 8'h80;
          rs_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SEND_ADDR: begin
        if (byte_done) begin
          state_d = SEND_DIGIT;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
          data_d  = chars[8*DIGITS-1 -: 8];
          rs_d    = 1'b1;
        end
      end
      SEND_DIGIT: begin
        if (byte_done) begin
          phase_d = PH_SETUP;
          cnt_d   = '0;
          if (idx_q == DIG_LAST) begin
            state_d = IDLE;
          end else begin
            idx_d  = nidx;
            data_d = chars[8*(DIGITS-1-int'(nidx)) +: 8];
          end
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PWR_WAIT;
      phase_q <= PH_SETUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      snap_q  <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      blank_q <= 1'b0;
      pend_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      snap_q  <= snap_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      pend_q  <= pend_d;
      run_q   <= run_d;
    end
  end

  assign data = data_q;
  assign rs   = rs_q;
  assign rw   = 1'b0;
  assign e    = (phase_q == PH_PULSE);
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_numeric_display.sv
// Bench for lcd_numeric_display: byte scoreboard on every e strobe,
// run against a 4-digit and a 3-digit instance sharing the inputs.
module tb_lcd_numeric_display;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] value = '0;
  logic        write = 1'b0;
  logic        blank_zeros = 1'b0;

  logic [7:0] data4, data3;
  logic       rs4, rw4, e4, busy4;
  logic       rs3, rw3, e3, busy3;

  always #5 clk = ~clk;

  lcd_numeric_display #(
    .VALUE_W(12), .DIGITS(4), .FRAME_CYCLES(300),
    .POWERUP_CYCLES(10), .E_PULSE_CYCLES(2),
    .CMD_WAIT_CYCLES(4), .CLEAR_WAIT_CYCLES(8)
  ) dut4 (
    .clk(clk), .reset_n(reset_n), .value(value),
    .write(write), .blank_zeros(blank_zeros),
    .data(data4), .rs(rs4), .rw(rw4), .e(e4), .busy(busy4)
  );

  lcd_numeric_display #(
    .VALUE_W(12), .DIGITS(3), .FRAME_CYCLES(300),
    .POWERUP_CYCLES(10), .E_PULSE_CYCLES(2),
    .CMD_WAIT_CYCLES(4), .CLEAR_WAIT_CYCLES(8)
  ) dut3 (
    .clk(clk), .reset_n(reset_n), .value(value),
    .write(write), .blank_zeros(blank_zeros),
    .data(data3), .rs(rs3), .rw(rw3), .e(e3), .busy(busy3)
  );

  typedef struct packed {
    logic       rs;
    logic [7:0] d;
  } byte_t;

  typedef struct packed {
    logic [11:0] v;
    logic        bz;
    logic [31:0] c4;
    logic [23:0] c3;
  } vec_t;

  byte_t q4[$];
  byte_t q3[$];
  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] x);
    nchk++;
    if (a !== x) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", n, a, x);
    end
  endtask

  // Strobe monitors: byte compare on rise, width/hold check on fall.
  logic pe4 = 1'b0, pe3 = 1'b0;
  int hw4 = 0, hw3 = 0;
  byte_t cap4, cap3, b4, b3;

  always @(negedge clk) begin
    if (e4 && !pe4) begin
      hw4 = 1;
      cap4 = '{rs4, data4};
      chk("rw4", {31'd0, rw4}, 32'd0);
      if (q4.size() > 0) begin
        b4 = q4.pop_front();
        chk("byte4", {23'd0, rs4, data4}, {23'd0, b4});
      end
    end else if (e4) begin
      hw4++;
    end else if (pe4 && reset_n) begin
      chk("ehigh4", 32'(hw4), 32'd2);
      chk("hold4", {23'd0, rs4, data4}, {23'd0, cap4});
    end
    pe4 = e4;
  end

  always @(negedge clk) begin
    if (e3 && !pe3) begin
      hw3 = 1;
      cap3 = '{rs3, data3};
      chk("rw3", {31'd0, rw3}, 32'd0);
      if (q3.size() > 0) begin
        b3 = q3.pop_front();
        chk("byte3", {23'd0, rs3, data3}, {23'd0, b3});
      end
    end else if (e3) begin
      hw3++;
    end else if (pe3 && reset_n) begin
      chk("ehigh3", 32'(hw3), 32'd2);
      chk("hold3", {23'd0, rs3, data3}, {23'd0, cap3});
    end
    pe3 = e3;
  end

  task automatic push_init();
    logic [31:0] cmds;
    cmds = 32'h380C0601;
    for (int i = 3; i >= 0; i--) begin
      q4.push_back('{1'b0, cmds[8*i +: 8]});
      q3.push_back('{1'b0, cmds[8*i +: 8]});
    end
  endtask

  task automatic push_frame(input logic [31:0] c4,
                            input logic [23:0] c3);
    q4.push_back('{1'b0, 8'h80});
    q3.push_back('{1'b0, 8'h80});
    for (int i = 3; i >= 0; i--) q4.push_back('{1'b1, c4[8*i +: 8]});
    for (int i = 2; i >= 0; i--) q3.push_back('{1'b1, c3[8*i +: 8]});
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy4 && !busy3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (q4.size() == 0 && q3.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("frame_drained", {31'd0, ok}, 32'd1);
    q4.delete();
    q3.delete();
  endtask

  task automatic pulse_write(input logic [11:0] v);
    @(negedge clk);
    value = v;
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  // Called right after reset_n rises.
  task automatic check_init();
    int n;
    n = 0;
    while (!e4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pwr_delay", {31'd0, (n >= 10 && n <= 14)}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (e4 && n < 50) begin
        @(negedge clk);
        n++;
      end
      n = 1;
      while (n < 50) begin
        @(negedge clk);
        if (e4) break;
        n++;
      end
      chk("cmd_gap", 32'(n), 32'd5);
    end
    n = 0;
    while (e4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (busy4 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("clear_gap", 32'(n), 32'd8);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  vec_t vt[12];
  int   n;

  initial begin
    vt[0]  = '{12'd670,  1'b0, 32'h30363730, 24'h363730};
    vt[1]  = '{12'd670,  1'b1, 32'h20363730, 24'h363730};
    vt[2]  = '{12'd0,    1'b1, 32'h20202030, 24'h202030};
    vt[3]  = '{12'd0,    1'b0, 32'h30303030, 24'h303030};
    vt[4]  = '{12'd4095, 1'b0, 32'h34303935, 24'h393939};
    vt[5]  = '{12'd4095, 1'b1, 32'h34303935, 24'h393939};
    vt[6]  = '{12'd5,    1'b1, 32'h20202035, 24'h202035};
    vt[7]  = '{12'd100,  1'b1, 32'h20313030, 24'h313030};
    vt[8]  = '{12'd1000, 1'b0, 32'h31303030, 24'h393939};
    vt[9]  = '{12'd999,  1'b1, 32'h20393939, 24'h393939};
    vt[10] = '{12'd1005, 1'b1, 32'h31303035, 24'h393939};
    vt[11] = '{12'd1234, 1'b0, 32'h31323334, 24'h393939};

    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, data4}, 32'd0);
    chk("rst_rs", {31'd0, rs4}, 32'd0);
    chk("rst_rw", {31'd0, rw4}, 32'd0);
    chk("rst_e", {31'd0, e4}, 32'd0);
    chk("rst_busy", {31'd0, busy4}, 32'd1);
    chk("rst_busy3", {31'd0, busy3}, 32'd1);

    push_init();
    @(negedge clk);
    #1 reset_n = 1'b1;
    check_init();

    for (int r = 0; r < 12; r++) begin
      wait_idle();
      blank_zeros = vt[r].bz;
      pulse_write(vt[r].v);
      push_frame(vt[r].c4, vt[r].c3);
      drain();
    end

    // Write landing mid-frame only shows up in the following frame.
    wait_idle();
    blank_zeros = 1'b0;
    pulse_write(12'd670);
    push_frame(32'h30363730, 24'h363730);
    n = 0;
    while (q4.size() != 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("in_send_digit", 32'(q4.size()), 32'd3);
    pulse_write(12'd123);
    push_frame(32'h30313233, 24'h313233);
    drain();

    // Reset during an e strobe restarts the whole init.
    n = 0;
    while (!e4 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_seen", {31'd0, e4}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_e", {31'd0, e4}, 32'd0);
    chk("midrst_busy", {31'd0, busy4}, 32'd1);
    chk("midrst_data", {24'd0, data4}, 32'd0);
    chk("midrst_e3", {31'd0, e3}, 32'd0);
    q4.delete();
    q3.delete();
    push_init();
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    check_init();

    wait_idle();
    blank_zeros = 1'b1;
    pulse_write(12'd42);
    push_frame(32'h20203432, 24'h203432);
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/lcd_numeric_display.md
LCD_NUMERIC_DISPLAY -- requirements
Module: lcd_numeric_display

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  VALUE_W, 12, binary input value width (4..16)
  DIGITS, 4, decimal characters shown (1..5)
  FRAME_CYCLES, 1666667, clk cycles per refresh frame (30 Hz at 50 MHz)
  POWERUP_CYCLES, 750000, clk cycles of power-on wait before init
  E_PULSE_CYCLES, 25, cycles e is held high per byte
  CMD_WAIT_CYCLES, 2500, cycles after each byte before the next
  CLEAR_WAIT_CYCLES, 100000, cycles after the clear command
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  system clock, all logic on rising edge
  reset_n  in  1  asynchronous active-low reset
  value  in  VALUE_W  binary number to display
  write  in  1  load strobe; value captured on any clk edge where write=1
  blank_zeros  in  1  1 = leading zeros shown as spaces
  data  out  8  LCD DB7..DB0
  rs  out  1  0 = command byte, 1 = character byte
  rw  out  1  LCD read/write, always 0
  e  out  1  LCD enable strobe
  busy  out  1  1 while init or a frame is in progress

Function
REQ-003 A shadow register SHALL capture value when write=1; the frame uses a snapshot of the shadow register taken at frame start, so write mid-frame affects only the next frame.
REQ-004 The state machine SHALL have states PWR_WAIT, INIT, IDLE, CONVERT, SEND_ADDR, SEND_DIGIT.
REQ-005 PWR_WAIT SHALL count POWERUP_CYCLES, then enter INIT.
REQ-006 INIT SHALL send the commands 0x38, 0x0C, 0x06, 0x01 in that order, then enter IDLE.
REQ-007 Every byte transfer SHALL use three phases: (1) drive data and rs with e=0 for 1 cycle; (2) e=1 for E_PULSE_CYCLES; (3) e=0 for CMD_WAIT_CYCLES, or CLEAR_WAIT_CYCLES after 0x01. data and rs SHALL stay stable through all three phases.
REQ-008 A free-running frame counter SHALL run from leaving INIT and raise a tick every FRAME_CYCLES cycles.
  - A tick while busy SHALL set a pending flag; multiple ticks SHALL coalesce into one pending frame.
  - IDLE SHALL start a frame on a tick or when the pending flag is set, and SHALL clear the pending flag.
REQ-009 CONVERT SHALL convert the snapshot to BCD by shift-add-3 (double dabble) in exactly VALUE_W cycles.
  - If the snapshot exceeds 10^DIGITS-1, every digit SHALL be 9 (saturation).
REQ-010 SEND_ADDR SHALL send command 0x80 (DDRAM address 0).
REQ-011 SEND_DIGIT SHALL send DIGITS characters, most significant first, with rs=1 and data = 0x30 + digit.
  - When blank_zeros=1, leading zero digits SHALL be sent as 0x20, except the least significant digit, which is always numeric.
  - blank_zeros SHALL be sampled at frame start.
REQ-012 After the last character the block SHALL return to IDLE.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 rw SHALL be 0 at all times.

Reset
REQ-015 While reset_n=0, outputs SHALL be: data=0x00, rs=0, rw=0, e=0, busy=1. The shadow register, snapshot, pending flag and all counters SHALL be 0, and the state SHALL be PWR_WAIT.
REQ-016 Deassertion of reset_n at any point, including mid-strobe, SHALL restart the full power-up and init sequence. Deassertion SHALL be synchronised to clk internally.

Verification (test parameters: POWERUP_CYCLES=10, E_PULSE_CYCLES=2, CMD_WAIT_CYCLES=4, CLEAR_WAIT_CYCLES=8, FRAME_CYCLES=300, VALUE_W=12, DIGITS=4)
REQ-017 Power-up: release reset -> after 10 cycles, e pulses for bytes 0x38, 0x0C, 0x06, 0x01 with rs=0; each e-high lasts 2 cycles; the gap after 0x01 is 8 cycles.
REQ-018 Value 670 written, blank_zeros=0 -> next frame bytes are 0x80 (rs=0), then 0x30, 0x36, 0x37, 0x30 (rs=1).
REQ-019 Value 670 written, blank_zeros=1 -> characters are 0x20, 0x36, 0x37, 0x30. Value 0 -> characters are 0x20, 0x20, 0x20, 0x30.
REQ-020 Value 4095 with DIGITS=3 -> characters are 0x39, 0x39, 0x39 (saturation).
REQ-021 write of 123 during SEND_DIGIT of a frame showing 670 -> the current frame finishes as 670; the next frame shows 0x30, 0x31, 0x32, 0x33.
REQ-022 reset_n pulsed low while e=1 -> e=0 and busy=1 immediately; the init sequence then repeats exactly as in REQ-017.
